// File: rtl/elevator_pkg.sv
// Shared defaults and the dispatcher state encoding for the elevator front-end.
package elevator_pkg;

  localparam int DEFAULT_FLOOR_W    = 3;
  localparam int DEFAULT_NUM_FLOORS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD1,
    ST_LOAD2,
    ST_DEST,
    ST_WAIT_START,
    ST_WAIT_DONE
  } disp_state_t;

endpackage

// File: rtl/elevator_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  // Scan from the lowest priority offset down so the closest requester to ptr wins last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_idx = PW'(idx);
        any     = 1'b1;
      end
    end
    if (any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Round-robin trip scheduler that drives the elevator load sequence and waits for trip completion.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FLOOR_W    = DEFAULT_FLOOR_W,
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int START_TO   = 8,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW = $clog2(START_TO + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FLOOR_W-1:0] req_origin,
  input  logic [NUM_REQ*FLOOR_W-1:0] req_dest,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       emergency_stop,
  input  logic                       idle,
  output logic                       en,
  output logic [FLOOR_W-1:0]         in_origin,
  output logic [FLOOR_W-1:0]         destination,
  output logic                       busy,
  output logic [GW-1:0]              grant_id,
  output logic                       err,
  output logic [7:0]                 trip_count
);

  disp_state_t        state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [FLOOR_W-1:0] dest_q, dest_d;
  logic [FLOOR_W-1:0] in_origin_q, in_origin_d;
  logic [FLOOR_W-1:0] destination_q, destination_d;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;
  logic [7:0]         trip_count_q, trip_count_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [GW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               grant_ok;
  logic [FLOOR_W-1:0] win_origin;
  logic [FLOOR_W-1:0] win_dest;
  logic               win_bad;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Decide whether a grant is offered this cycle and pick out the winner's trip.
  always_comb begin
    grant_ok   = (state_q == ST_IDLE) && idle && !emergency_stop && gnt_any && !reset;
    req_ready  = grant_ok ? gnt : '0;
    win_origin = req_origin[int'(gnt_idx) * FLOOR_W +: FLOOR_W];
    win_dest   = req_dest[int'(gnt_idx) * FLOOR_W +: FLOOR_W];
    win_bad    = (int'(win_origin) >= NUM_FLOORS) || (int'(win_dest) >= NUM_FLOORS);
  end

  // Next-state logic for the trip sequence, capture registers, timeout and trip counter.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    dest_d        = dest_q;
    in_origin_d   = in_origin_q;
    destination_d = destination_q;
    trip_count_d  = trip_count_q;
    to_cnt_d      = '0;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          grant_id_d = gnt_idx;
          dest_d     = win_dest;
          rr_ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          if (win_bad) begin
            err_d = 1'b1;
          end else begin
            in_origin_d = win_origin;
            state_d     = ST_LOAD1;
          end
        end
      end
      ST_LOAD1: state_d = ST_LOAD2;
      ST_LOAD2: state_d = ST_DEST;
      ST_DEST: begin
        destination_d = dest_q;
        state_d       = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!idle) begin
          state_d = ST_WAIT_DONE;
        end else if (emergency_stop) begin
          to_cnt_d = to_cnt_q;
        end else if (to_cnt_q == TW'(START_TO - 1)) begin
          state_d      = ST_IDLE;
          trip_count_d = trip_count_q + 8'd1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (idle) begin
          state_d      = ST_IDLE;
          trip_count_d = trip_count_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    en_d   = (state_d == ST_LOAD1) || (state_d == ST_LOAD2);
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any captured request on the floor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      dest_q        <= '0;
      in_origin_q   <= '0;
      destination_q <= '0;
      to_cnt_q      <= '0;
      trip_count_q  <= '0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      dest_q        <= dest_d;
      in_origin_q   <= in_origin_d;
      destination_q <= destination_d;
      to_cnt_q      <= to_cnt_d;
      trip_count_q  <= trip_count_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign en          = en_q;
  assign in_origin   = in_origin_q;
  assign destination = destination_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign err         = err_q;
  assign trip_count  = trip_count_q;

endmodule
